migu_insn_fetch: RTL and testbench
==================================

Name: migu_insn_fetch

Overview:
- Instruction-fetch front end for the Mig-U core; the read-side initiator for the core's word-addressed instruction SRAM.
- Issues sequential word reads starting at rst_addr and tags each returned word with its PC.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect: flushes buffered words and discards in-flight responses.

Parameters:
ADDR_WIDTH, 32, byte-address width; word PC is ADDR_WIDTH-2 bits ([ADDR_WIDTH-1:2]).
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2).
MAX_OUTSTANDING, 2, maximum SRAM reads in flight (>=1, <=FIFO_DEPTH).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
rst_addr  in  ADDR_WIDTH-2  boot word address, sampled during rst.
fetch_en  in  1  when low, issue no new requests; responses are still accepted.
redirect_valid  in  1  one-cycle pulse to restart fetch at redirect_addr.
redirect_addr  in  ADDR_WIDTH-2  new word PC.
mem_rd_en  out  1  SRAM read request strobe.
mem_rd_addr  out  ADDR_WIDTH-2  SRAM word address, valid when mem_rd_en=1.
mem_rd_valid  in  1  SRAM read data valid; one per request, in request order, latency >=1 cycle.
mem_rd_data  in  32  SRAM read data.
insn_valid  out  1  buffer head valid.
insn_ready  in  1  decode accepts the head.
insn_data  out  32  head instruction word.
insn_pc  out  ADDR_WIDTH-2  head word PC.

Behaviour:
- Reset (any cycle, including mid-operation):
  - pc<=rst_addr; FIFO, outstanding count, discard count and address queue cleared; state<=BOOT.
  - Outputs during and on the cycle after rst: mem_rd_en=0, insn_valid=0, insn_data=0, insn_pc=0.
- FSM states:
  - BOOT: no request; next state FETCH (or redirect handling if redirect_valid).
  - FETCH: issue when fetch_en && outstanding<MAX_OUTSTANDING && (outstanding+fifo_count)<FIFO_DEPTH.
  - FLUSH: no requests; drops each mem_rd_valid and decrements discard; enters FETCH in the cycle after discard reaches 0.
- Issue rules:
  - mem_rd_en is combinational from state/counters; mem_rd_addr=pc.
  - On issue, pc<=pc+1 modulo 2^(ADDR_WIDTH-2): all-ones wraps to 0.
  - The issued address is pushed into the request-address queue (depth MAX_OUTSTANDING).
- Response (FETCH, discard=0): {mem_rd_data, addr-queue head} is pushed into the FIFO in the same edge; addr-queue pops; outstanding decrements.
- Credit rule: the FIFO can never overflow. Push and pop in the same cycle are both honoured.
- Simultaneous issue and response: outstanding is unchanged.
- Output:
  - insn_valid = fifo_count!=0; insn_data/insn_pc come from the head register.
  - Pop on insn_valid&&insn_ready. Holding insn_ready low keeps the head stable.
- Redirect (redirect_valid=1, any non-reset state; highest priority after rst):
  - FIFO cleared; insn_valid=0 from the next cycle; no pop is reported that cycle.
  - pc<=redirect_addr; no issue that cycle; address queue cleared.
  - discard<=outstanding minus (1 if mem_rd_valid this cycle).
  - Next state: FLUSH if discard!=0, else FETCH. The first request to redirect_addr goes out the next cycle at the earliest.
  - A redirect while in FLUSH reloads pc and recomputes discard the same way.
- mem_rd_valid with outstanding=0 is a protocol violation: data is ignored and a simulation assertion fires.
- fetch_en low: in-flight responses still land; pc holds.

Decomposition:
- Package migu_pkg:
  - RISCV_INSN_WIDTH=32.
  - insn_t (32-bit word).
  - fetch_state_e {BOOT, FETCH, FLUSH}.
  - fetch_entry_t {insn_t data; word PC}, parameterised via ADDR_WIDTH localparam in the module.
- Sub-module: migu_sync_fifo (parameterised width/depth, synchronous clear, count output).
  - Used twice: the instruction buffer and the request-address queue.

Test Plan:
- Boot, latency-1 SRAM model, rst_addr=0x100, insn_ready=1 → requests to 0x100,0x101,0x102…; insn_pc follows the same sequence with the matching data.
- insn_ready=0 for 20 cycles → exactly FIFO_DEPTH=4 words buffered, and mem_rd_en never asserted while outstanding+count=4. Release → words 0x100..0x103 drained in order, fetch resumes at 0x104.
- Latency-3 SRAM with 2 outstanding; redirect to 0x200 → both in-flight responses dropped (FLUSH lasts until both return), first insn_pc=0x200, no stale word ever valid.
- rst_addr=all-ones (0x3FFFFFFF, ADDR_WIDTH=32) → second request address 0x0; insn_pc wraps identically.
- Redirect coinciding with a response and a pop → discard=outstanding-1, FIFO empty next cycle, no duplicate or lost word.
- rst asserted mid-stream with 2 outstanding → outputs zero the next cycle; late responses after reset are ignored by the assertion-checked model; fetch restarts at the new rst_addr.

Source files
------------

// File: rtl/migu_pkg.sv
// Shared types for the Mig-U instruction-fetch front end.
package migu_pkg;

  localparam int RISCV_INSN_WIDTH = 32;

  typedef logic [RISCV_INSN_WIDTH-1:0] insn_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/migu_sync_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count.
// The head is read from the storage array without a register, so it is visible in the same cycle.
module migu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= next_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/migu_insn_fetch.sv
// Instruction-fetch front end: sequential SRAM reads, PC tagging, an instruction buffer, and redirect.
// In-flight reads are credit-limited so the instruction buffer can never overflow.
module migu_insn_fetch
  import migu_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-3:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [31:0]           insn_data,
  output logic [ADDR_WIDTH-3:0] insn_pc
);

  localparam int PC_W       = ADDR_WIDTH - 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    insn_t           data;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  fetch_state_e     state_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [OUT_W-1:0] outstanding_reg;
  logic [OUT_W-1:0] discard_reg;
  logic [OUT_W-1:0] outstanding_next;
  logic [OUT_W-1:0] redirect_discard;
  logic [31:0]      occupancy;

  logic             resp_ok;
  logic             issue;
  logic             buf_push;
  logic             buf_pop;
  fetch_entry_t     buf_push_entry;
  fetch_entry_t     buf_head;
  logic [FIFO_CNT_W-1:0] buf_count;
  logic [PC_W-1:0]  aq_head;
  logic [OUT_W-1:0] aq_count;

  assign resp_ok   = mem_rd_valid && (outstanding_reg != '0);
  assign occupancy = 32'(outstanding_reg) + 32'(buf_count);

  assign issue = !rst && (state_reg == FETCH) && fetch_en && !redirect_valid
              && (outstanding_reg < OUT_W'(MAX_OUTSTANDING))
              && (occupancy < 32'(FIFO_DEPTH));

  // A response landing on a redirect edge belongs to the old stream, so it is dropped with the rest.
  assign buf_push = resp_ok && (state_reg == FETCH) && (discard_reg == '0)
                 && !redirect_valid && (aq_count != '0);
  assign buf_pop  = (buf_count != '0) && insn_ready && !redirect_valid;

  assign buf_push_entry.data = mem_rd_data;
  assign buf_push_entry.pc   = aq_head;

  assign outstanding_next = outstanding_reg + OUT_W'(issue) - OUT_W'(resp_ok);
  assign redirect_discard = outstanding_reg - OUT_W'(resp_ok);

  migu_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_insn_buf (
    .clk       (clk),
    .srst      (rst),
    .clr       (redirect_valid),
    .push      (buf_push),
    .push_data (buf_push_entry),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count)
  );

  migu_sync_fifo #(
    .WIDTH (PC_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_queue (
    .clk       (clk),
    .srst      (rst),
    .clr       (redirect_valid),
    .push      (issue),
    .push_data (pc_reg),
    .pop       (buf_push),
    .head_data (aq_head),
    .count     (aq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= rst_addr;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (redirect_valid) begin
        pc_reg      <= redirect_addr;
        discard_reg <= redirect_discard;
        state_reg   <= (redirect_discard != '0) ? FLUSH : FETCH;
      end else begin
        case (state_reg)
          BOOT: state_reg <= FETCH;
          FETCH: begin
            if (issue) begin
              pc_reg <= pc_reg + 1'b1;
            end
          end
          FLUSH: begin
            // Leave as soon as the last stale response has been swallowed.
            if (resp_ok && (discard_reg != '0)) begin
              discard_reg <= discard_reg - 1'b1;
            end
            if ((discard_reg == '0) || (resp_ok && (discard_reg == OUT_W'(1)))) begin
              state_reg <= FETCH;
            end
          end
          default: state_reg <= BOOT;
        endcase
      end
    end
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = pc_reg;
  assign insn_valid  = !rst && (buf_count != '0);
  assign insn_data   = rst ? '0 : buf_head.data;
  assign insn_pc     = rst ? '0 : buf_head.pc;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rd_valid && (outstanding_reg == '0)))
        else $error("migu_insn_fetch: mem_rd_valid with no read outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_migu_insn_fetch.sv
// Bench for migu_insn_fetch: boot vector table, directed corner sequences, and randomized traffic
// checked against a queue-based model of the SRAM and the instruction stream.
module tb_migu_insn_fetch;

  localparam int PW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] rst_addr;
  logic          fetch_en;
  logic          redirect_valid;
  logic [PW-1:0] redirect_addr;
  logic          mem_rd_en;
  logic [PW-1:0] mem_rd_addr;
  logic          mem_rd_valid;
  logic [31:0]   mem_rd_data;
  logic          insn_valid;
  logic          insn_ready;
  logic [31:0]   insn_data;
  logic [PW-1:0] insn_pc;

  always #5 clk = ~clk;

  migu_insn_fetch #(
    .ADDR_WIDTH      (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_addr       (rst_addr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc)
  );

  typedef struct { logic [PW-1:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [PW-1:0] pc; logic [31:0] data; } word_t;
  typedef struct { logic [PW-1:0] rst_addr; int lat; logic [PW-1:0] exp0, exp1, exp2; } boot_vec_t;

  req_t          sram_q[$];
  word_t         fq[$];
  logic [PW-1:0] req_log[$];
  logic [PW-1:0] acc_log[$];
  logic [PW-1:0] issue_pc;
  int epoch, cyc, last_due, lat_min, lat_max;
  bit post_rst;
  int n_vec, n_err;
  boot_vec_t tbl[4];

  function automatic logic [31:0] data_fn(input logic [PW-1:0] a);
    return {a, 2'b11} ^ 32'hC0DE_0000;
  endfunction

  function automatic bit stale_pending();
    foreach (sram_q[i]) if (sram_q[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [PW-1:0] pick_addr();
    logic [PW-1:0] a;
    if ($urandom_range(0, 3) == 0) a = 30'h3FFF_FFFE + 30'($urandom_range(0, 1));
    else a = 30'($urandom);
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: present the SRAM response, check mid-cycle, apply the edge to the model.
  task automatic tick();
    bit    resp;
    bit    pop;
    int    due;
    req_t  r;
    word_t w;
    resp = (sram_q.size() != 0) && (sram_q[0].due <= cyc) && !rst;
    mem_rd_valid = resp;
    mem_rd_data  = resp ? data_fn(sram_q[0].addr) : 32'h0;
    #4;
    if (rst) begin
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_valid", insn_valid, 0);
      check("rst_data", insn_data, 0);
      check("rst_pc", insn_pc, 0);
      issue_pc = rst_addr;
      fq.delete();
      sram_q.delete();
      epoch++;
      last_due = 0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("post_rst_rd_en", mem_rd_en, 0);
        check("post_rst_data", insn_data, 0);
        check("post_rst_pc", insn_pc, 0);
        post_rst = 1'b0;
      end
      check("insn_valid", insn_valid, fq.size() != 0);
      if (fq.size() != 0) begin
        check("insn_pc", insn_pc, fq[0].pc);
        check("insn_data", insn_data, fq[0].data);
      end
      if (mem_rd_en) begin
        check("issue_addr", mem_rd_addr, issue_pc);
        check("issue_allowed", (sram_q.size() < 2) && (sram_q.size() + fq.size() < 4)
              && fetch_en && !redirect_valid && !stale_pending(), 1);
      end
      pop = (fq.size() != 0) && insn_ready && !redirect_valid;
      if (pop) begin
        w = fq.pop_front();
        acc_log.push_back(w.pc);
        $display("cycle %0d insn pc=%h data=%h", cyc, w.pc, w.data);
      end
      if (resp) begin
        r = sram_q.pop_front();
        if (r.epoch == epoch && !redirect_valid) begin
          w.pc = r.addr;
          w.data = data_fn(r.addr);
          fq.push_back(w);
        end
      end
      if (mem_rd_en) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = issue_pc;
        r.epoch = epoch;
        r.due = due;
        sram_q.push_back(r);
        req_log.push_back(issue_pc);
        issue_pc = issue_pc + 1'b1;
      end
      if (redirect_valid) begin
        fq.delete();
        epoch++;
        issue_pc = redirect_addr;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [PW-1:0] a);
    rst = 1'b1;
    rst_addr = a;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    req_log.delete();
    acc_log.delete();
  endtask

  task automatic run_until_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, acc_log.size() >= n, 1);
  endtask

  task automatic wait_pending2(input string name);
    int k = 0;
    while (sram_q.size() != 2 && k < 30) begin
      tick();
      k++;
    end
    check(name, sram_q.size(), 2);
  endtask

  task automatic check_acc_seq(input string name, input logic [PW-1:0] base, input int n);
    if (acc_log.size() >= n) begin
      for (int j = 0; j < n; j++) check(name, acc_log[j], base + PW'(j));
    end
  endtask

  initial begin
    logic [PW-1:0] e[3];
    int k;
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0; post_rst = 1'b0;
    lat_min = 1; lat_max = 1;
    rst = 1'b1; rst_addr = '0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    insn_ready = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = '0; issue_pc = '0;

    tbl[0] = '{30'h100,        1, 30'h100,        30'h101,        30'h102};
    tbl[1] = '{30'h3FFF_FFFF,  1, 30'h3FFF_FFFF,  30'h0,          30'h1};
    tbl[2] = '{30'h3FFF_FFFE,  3, 30'h3FFF_FFFE,  30'h3FFF_FFFF,  30'h0};
    tbl[3] = '{30'h0,          2, 30'h0,          30'h1,          30'h2};

    for (int i = 0; i < 4; i++) begin
      $display("boot vector %0d rst_addr=%h latency=%0d", i, tbl[i].rst_addr, tbl[i].lat);
      lat_min = tbl[i].lat; lat_max = tbl[i].lat;
      fetch_en = 1'b1; insn_ready = 1'b1;
      do_reset(tbl[i].rst_addr);
      run_until_acc(3, 60, "boot_progress");
      e[0] = tbl[i].exp0; e[1] = tbl[i].exp1; e[2] = tbl[i].exp2;
      if (acc_log.size() >= 3 && req_log.size() >= 3) begin
        for (int j = 0; j < 3; j++) begin
          check("boot_req_addr", req_log[j], e[j]);
          check("boot_insn_pc", acc_log[j], e[j]);
        end
      end
    end

    // Backpressure: buffer fills to exactly four words, then drains in order.
    lat_min = 1; lat_max = 1;
    do_reset(30'h100);
    insn_ready = 1'b0;
    repeat (20) tick();
    check("bp_req_count", req_log.size(), 4);
    check("bp_valid_held", insn_valid, 1);
    check("bp_head_pc", insn_pc, 30'h100);
    insn_ready = 1'b1;
    run_until_acc(5, 40, "bp_drain");
    check_acc_seq("bp_order", 30'h100, 5);
    if (req_log.size() >= 5) check("bp_resume_addr", req_log[4], 30'h104);

    // Redirect with two latency-3 reads in flight.
    lat_min = 3; lat_max = 3;
    do_reset(30'h100);
    wait_pending2("rd_two_pending");
    redirect_valid = 1'b1; redirect_addr = 30'h200;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete();
    run_until_acc(3, 60, "rd_progress");
    check_acc_seq("rd_after_redirect", 30'h200, 3);

    // Redirect on the same cycle as a response and a pop.
    lat_min = 2; lat_max = 2;
    do_reset(30'h100);
    k = 0;
    while (!(fq.size() != 0 && sram_q.size() != 0 && sram_q[0].due <= cyc) && k < 30) begin
      tick();
      k++;
    end
    check("rc_found_overlap", k < 30, 1);
    redirect_valid = 1'b1; redirect_addr = 30'h300;
    tick();
    redirect_valid = 1'b0;
    check("rc_empty_next", insn_valid, 0);
    acc_log.delete();
    run_until_acc(4, 60, "rc_progress");
    check_acc_seq("rc_after_redirect", 30'h300, 4);

    // Reset mid-stream with two reads in flight; the SRAM model drops them.
    lat_min = 3; lat_max = 3;
    do_reset(30'h100);
    wait_pending2("mr_two_pending");
    do_reset(30'h40);
    run_until_acc(2, 60, "mr_progress");
    check_acc_seq("mr_restart", 30'h40, 2);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    do_reset(pick_addr());
    for (int i = 0; i < 2500; i++) begin
      insn_ready     = $urandom_range(0, 3) != 0;
      fetch_en       = $urandom_range(0, 9) != 0;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_addr  = pick_addr();
      rst            = $urandom_range(0, 199) == 0;
      rst_addr       = pick_addr();
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; insn_ready = 1'b1;
    acc_log.delete();
    run_until_acc(4, 80, "rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
